mux_select_sequencer: RTL and testbench

// Upstream control stage for the 4:1 mux. Drives the S1/S0 selects, scanning

---
 rtl/mux_select_sequencer.sv | 104 ++++++++++
 tb/tb_mux_select_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_select_sequencer.sv
// Select sequencer for a 4:1 mux: scans the enabled channels with a programmable
// dwell per channel, strobing 'sample' on the last dwell cycle of each channel.
module mux_select_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [3:0]         ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic               S0,
    output logic               S1,
    output logic [1:0]         ch_idx,
    output logic               sample,
    output logic               busy,
    output logic               done
);

    typedef enum logic {IDLE, SCAN} state_t;

    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    state_t             state;
    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] dwell_l;
    logic [3:0]         mask_l;
    logic               has_next;
    logic [1:0]         next_ch;

    function automatic logic [1:0] lowest(input logic [3:0] m);
        logic [1:0] lo;
        lo = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lo = 2'(i);
        end
        return lo;
    endfunction

    // Next enabled channel strictly above the current one; descending scan so the nearest wins.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        has_next = 1'b0;
        next_ch  = ch_idx;
        for (int i = 3; i >= 0; i--) begin
            if (mask_l[i] && (i > int'(ch_idx))) begin
                has_next = 1'b1;
                next_ch  = 2'(i);
            end
        end
    end

    assign sample = (state == SCAN) && (count == dwell_l - ONE);
    assign busy   = (state == SCAN);
    assign S0     = ch_idx[0];
    assign S1     = ch_idx[1];

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch_idx  <= 2'd0;
            count   <= '0;
            dwell_l <= '0;
            mask_l  <= 4'd0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop && (ch_mask != 4'd0)) begin
                        mask_l  <= ch_mask;
                        dwell_l <= (dwell == '0) ? ONE : dwell;
                        ch_idx  <= lowest(ch_mask);
                        count   <= '0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (stop) begin
                        // Abort wins even on a sample cycle: no advance, no done.
                        state <= IDLE;
                        count <= '0;
                    end else if (sample) begin
                        count <= '0;
                        if (has_next) begin
                            ch_idx <= next_ch;
                        end else if (continuous) begin
                            ch_idx <= lowest(mask_l);
                        end else begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end else begin
                        count <= count + ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Directed bench for mux_select_sequencer: one task per scenario, expected
// values computed from hand-derived cycle formulas.
module tb_mux_select_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic       continuous;
    logic [3:0] ch_mask;
    logic [7:0] dwell;
    logic       S0;
    logic       S1;
    logic [1:0] ch_idx;
    logic       sample;
    logic       busy;
    logic       done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Observed bundle: {ch_idx, S1, S0, sample, busy, done}
    logic [6:0] obs;
    assign obs = {ch_idx, S1, S0, sample, busy, done};

    mux_select_sequencer #(.DWELL_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .stop       (stop),
        .continuous (continuous),
        .ch_mask    (ch_mask),
        .dwell      (dwell),
        .S0         (S0),
        .S1         (S1),
        .ch_idx     (ch_idx),
        .sample     (sample),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; outputs are sampled and inputs driven 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        ch_mask = 4'd0; dwell = 8'd0;
        #12;
        total_cnt++;
        if (obs !== 7'd0) $display("FAIL reset_init obs=%b exp=%b", obs, 7'd0);
        else pass_cnt++;
        rst_n = 1'b1;
        step();
        // Start a scan, then hit reset when count reaches 2.
        ch_mask = 4'hF; dwell = 8'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        exp = {2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        total_cnt++;
        if (obs !== exp) $display("FAIL reset_prescan obs=%b exp=%b", obs, exp);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (obs !== 7'd0) $display("FAIL reset_async obs=%b exp=%b", obs, 7'd0);
        else pass_cnt++;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            total_cnt++;
            if (obs !== 7'd0) $display("FAIL reset_after c=%0d obs=%b exp=%b", c, obs, 7'd0);
            else pass_cnt++;
        end
    endtask

    // Mask 4'hF, dwell 3, one-shot. Optionally pokes start/mask/dwell at cycle 2.
    task automatic run_full_oneshot(input bit disturb, input string tag);
        logic [1:0] ech;
        logic [6:0] exp;
        ch_mask = 4'hF; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
        for (int c = 1; c <= 15; c++) begin
            step();
            start = 1'b0;
            if (disturb && c == 2) begin
                start = 1'b1; ch_mask = 4'b0001; dwell = 8'd7;
            end
            if (disturb && c == 3) start = 1'b0;
            ech = (c <= 12) ? 2'((c - 1) / 3) : 2'd3;
            exp = {ech, ech[1], ech[0],
                   1'((c <= 12) && (c % 3 == 0)),
                   1'(c <= 12),
                   1'(c == 13)};
            total_cnt++;
            if (obs !== exp) $display("FAIL %s c=%0d obs=%b exp=%b", tag, c, obs, exp);
            else pass_cnt++;
        end
        ch_mask = 4'd0; dwell = 8'd0;
    endtask

    task automatic test_one_shot();
        run_full_oneshot(1'b0, "oneshot");
    endtask

    task automatic test_continuous();
        logic [1:0] ech;
        logic [6:0] exp;
        ch_mask = 4'b1010; dwell = 8'd2; continuous = 1'b1; start = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            step();
            start = 1'b0;
            if (c <= 16) begin
                ech = (((c - 1) / 2) % 2 == 0) ? 2'd1 : 2'd3;
                exp = {ech, ech[1], ech[0], 1'(c % 2 == 0), 1'b1, 1'b0};
            end else begin
                ech = 2'd3;
                exp = {ech, ech[1], ech[0], 1'b0, 1'b0, 1'(c == 17)};
            end
            total_cnt++;
            if (obs !== exp) $display("FAIL continuous c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
            if (c == 13) continuous = 1'b0;
        end
        ch_mask = 4'd0;
    endtask

    task automatic test_dwell_zero();
        logic [6:0] exp;
        // One-shot, single channel 2, dwell 0 behaves as dwell 1.
        ch_mask = 4'b0100; dwell = 8'd0; continuous = 1'b0; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            exp = {2'd2, 1'b1, 1'b0, 1'(c == 1), 1'(c == 1), 1'(c == 2)};
            total_cnt++;
            if (obs !== exp) $display("FAIL dwell0_oneshot c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
        // Continuous single channel: sample every cycle; stop lands on a sample cycle.
        continuous = 1'b1; start = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            step();
            start = 1'b0;
            exp = (c <= 4) ? {2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}
                           : {2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL dwell0_cont c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
            stop = (c == 4);
        end
        stop = 1'b0; continuous = 1'b0; ch_mask = 4'd0;
    endtask

    task automatic test_stop();
        logic [1:0] ech;
        logic [6:0] exp;
        ch_mask = 4'hF; dwell = 8'd3; continuous = 1'b0; start = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            step();
            start = 1'b0;
            stop  = 1'b0;
            ech = (c <= 3) ? 2'd0 : 2'd1;
            exp = {ech, ech[1], ech[0], 1'(c == 3), 1'(c <= 4), 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL stop c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
            if (c == 4) stop = 1'b1;
        end
        // Start with an empty mask is ignored.
        ch_mask = 4'b0000; start = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            step();
            start = 1'b0;
            exp = {2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
            total_cnt++;
            if (obs !== exp) $display("FAIL empty_mask c=%0d obs=%b exp=%b", c, obs, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_ignore_changes();
        run_full_oneshot(1'b1, "midscan_changes");
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_continuous();
        test_dwell_zero();
        test_stop();
        test_ignore_changes();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
